adc_sum_sq_accum: RTL and testbench

ADC_SUM_SQ_ACCUM -- requirements
Module: adc_sum_sq_accum

---
 rtl/adc_sum_sq_accum.sv | 127 ++++++++++++
 tb/tb_adc_sum_sq_accum.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adc_sum_sq_accum.sv
// Windowed sum-of-squares accumulator for a 4-sample-per-clock ADC stream.
// Pipeline: S1 squares, S2 lane sum, S3 saturating accumulate and dump.
module adc_sum_sq_accum #(
  parameter int ADC_BITS     = 8,
  parameter int ACC_LEN_LOG2 = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [4*ADC_BITS-1:0] adc_data,
  input  logic                  adc_valid,
  input  logic                  sync,
  output logic [31:0]           sum_sq,
  output logic                  sum_valid,
  output logic                  sum_sat,
  output logic [15:0]           dump_count
);

  localparam int SQ_W   = 2*ADC_BITS-1;
  localparam int TERM_W = 2*ADC_BITS+1;
  localparam int ADD_W  = ((TERM_W > 32) ? TERM_W : 32) + 1;

  // S1: per-lane squares
  logic [SQ_W-1:0] sq_d [4];
  logic [SQ_W-1:0] sq_q [4];
  logic            valid1_q, sync1_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sq
      logic signed [ADC_BITS-1:0] smp;
      assign smp       = adc_data[gi*ADC_BITS +: ADC_BITS];
      assign sq_d[gi]  = SQ_W'(smp * smp);
    end
  endgenerate

  // S2: lane sum
  logic [TERM_W-1:0] term_d, term_q;
  logic              valid2_q, sync2_q;

  assign term_d = TERM_W'(sq_q[0]) + TERM_W'(sq_q[1]) + TERM_W'(sq_q[2]) + TERM_W'(sq_q[3]);

  // S3: accumulator and reported results
  logic [31:0]             acc_d, acc_q;
  logic [ACC_LEN_LOG2-1:0] cnt_d, cnt_q;
  logic                    wsat_d, wsat_q;
  logic [31:0]             sum_sq_d, sum_sq_q;
  logic                    sum_valid_d, sum_valid_q;
  logic                    sum_sat_d, sum_sat_q;
  logic [15:0]             dump_count_d, dump_count_q;

  logic [31:0]      add_base;
  logic [ADD_W-1:0] add_full;
  logic             add_ovf;
  logic [31:0]      add_sat;

  // A sync sample discards the partial window, so it adds onto zero.
  assign add_base = sync2_q ? 32'd0 : acc_q;
  assign add_full = ADD_W'(add_base) + ADD_W'(term_q);
  assign add_ovf  = |add_full[ADD_W-1:32];
  assign add_sat  = add_ovf ? 32'hFFFF_FFFF : add_full[31:0];

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wsat_d       = wsat_q;
    sum_sq_d     = sum_sq_q;
    sum_valid_d  = 1'b0;
    sum_sat_d    = sum_sat_q;
    dump_count_d = dump_count_q;
    if (valid2_q) begin
      if (sync2_q) begin
        acc_d  = add_sat;
        cnt_d  = ACC_LEN_LOG2'(1);
        wsat_d = add_ovf;
      end else if (cnt_q == '1) begin
        sum_sq_d     = add_sat;
        sum_sat_d    = wsat_q | add_ovf;
        sum_valid_d  = 1'b1;
        dump_count_d = dump_count_q + 16'd1;
        acc_d        = 32'd0;
        cnt_d        = '0;
        wsat_d       = 1'b0;
      end else begin
        acc_d  = add_sat;
        cnt_d  = cnt_q + ACC_LEN_LOG2'(1);
        wsat_d = wsat_q | add_ovf;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      for (int i = 0; i < 4; i++) sq_q[i] <= '0;
      valid1_q     <= 1'b0;
      sync1_q      <= 1'b0;
      term_q       <= '0;
      valid2_q     <= 1'b0;
      sync2_q      <= 1'b0;
      acc_q        <= 32'd0;
      cnt_q        <= '0;
      wsat_q       <= 1'b0;
      sum_sq_q     <= 32'd0;
      sum_valid_q  <= 1'b0;
      sum_sat_q    <= 1'b0;
      dump_count_q <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) sq_q[i] <= sq_d[i];
      valid1_q     <= adc_valid;
      sync1_q      <= adc_valid & sync;
      term_q       <= term_d;
      valid2_q     <= valid1_q;
      sync2_q      <= sync1_q;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wsat_q       <= wsat_d;
      sum_sq_q     <= sum_sq_d;
      sum_valid_q  <= sum_valid_d;
      sum_sat_q    <= sum_sat_d;
      dump_count_q <= dump_count_d;
    end
  end

  assign sum_sq     = sum_sq_q;
  assign sum_valid  = sum_valid_q;
  assign sum_sat    = sum_sat_q;
  assign dump_count = dump_count_q;

endmodule

// File: tb/tb_adc_sum_sq_accum.sv
// Directed bench for adc_sum_sq_accum: 8-bit instance for windowing/sync/reset,
// 16-bit instance to reach the 32-bit saturation point in a short window.
module tb_adc_sum_sq_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] sum_sq;
  logic        sum_valid, sum_sat;
  logic [15:0] dump_count;

  logic [63:0] w_data = '0;
  logic        w_valid = 1'b0;
  logic        w_sync = 1'b0;
  logic [31:0] w_sum_sq;
  logic        w_sum_valid, w_sum_sat;
  logic [15:0] w_dump_count;

  int   errors = 0;
  int   checks = 0;
  logic seen;

  always #5 clk = ~clk;

  adc_sum_sq_accum #(.ADC_BITS(8), .ACC_LEN_LOG2(2)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .sync(sync), .sum_sq(sum_sq), .sum_valid(sum_valid), .sum_sat(sum_sat),
    .dump_count(dump_count)
  );

  adc_sum_sq_accum #(.ADC_BITS(16), .ACC_LEN_LOG2(2)) dut_w (
    .user_clk(clk), .user_rst_n(rst_n), .adc_data(w_data), .adc_valid(w_valid),
    .sync(w_sync), .sum_sq(w_sum_sq), .sum_valid(w_sum_valid), .sum_sat(w_sum_sat),
    .dump_count(w_dump_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one cycle of main-instance input just after the rising edge; wide instance idles.
  task automatic send(input logic [31:0] d, input logic v, input logic s);
    @(posedge clk);
    #1;
    adc_data = d;
    adc_valid = v;
    sync = s;
    w_data = '0;
    w_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic v);
    send(32'd0, 1'b0, 1'b0);
    w_data = d;
    w_valid = v;
  endtask

  task automatic expect_dump(input string tag, input logic [31:0] e_sum, input logic e_sat,
                             input logic [15:0] e_cnt);
    for (int i = 1; i <= 3; i++) begin
      send(32'd0, 1'b0, 1'b0);
      @(negedge clk);
      check({tag, "_lat"}, sum_valid, (i == 3));
    end
    check({tag, "_sum"}, sum_sq, e_sum);
    check({tag, "_sat"}, sum_sat, e_sat);
    check({tag, "_cnt"}, dump_count, e_cnt);
    send(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, "_pulse"}, sum_valid, 1'b0);
    check({tag, "_hold"}, sum_sq, e_sum);
  endtask

  task automatic expect_dump_w(input string tag, input logic [31:0] e_sum, input logic e_sat,
                               input logic [15:0] e_cnt);
    for (int i = 1; i <= 3; i++) begin
      send_w(64'd0, 1'b0);
      @(negedge clk);
      check({tag, "_lat"}, w_sum_valid, (i == 3));
    end
    check({tag, "_sum"}, w_sum_sq, e_sum);
    check({tag, "_sat"}, w_sum_sat, e_sat);
    check({tag, "_cnt"}, w_dump_count, e_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("rst_sum", sum_sq, 32'd0);
    check("rst_valid", sum_valid, 1'b0);
    check("rst_sat", sum_sat, 1'b0);
    check("rst_cnt", dump_count, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ones window: 4 cycles x 4 lanes x 1
    repeat (4) send(32'h0101_0101, 1'b1, 1'b0);
    expect_dump("ones", 32'd16, 1'b0, 16'd1);

    // Extremes: 4 x (16384 + 16129 + 1 + 0)
    repeat (4) send(32'h00FF_7F80, 1'b1, 1'b0);
    expect_dump("extreme", 32'd130056, 1'b0, 16'd2);

    // Gapped valid; data on invalid cycles must be ignored
    for (int i = 0; i < 7; i++)
      send((i % 2 == 0) ? 32'h0101_0101 : 32'h7F7F_7F7F, (i % 2 == 0), 1'b0);
    expect_dump("gapped", 32'd16, 1'b0, 16'd3);

    // Sync on 3rd sample restarts window; 4 x 16 = 64
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send((i < 2) ? 32'h0101_0101 : 32'h0202_0202, 1'b1, (i == 2));
      @(negedge clk);
      seen |= sum_valid;
    end
    check("sync_mid_nodump", seen, 1'b0);
    expect_dump("sync_mid", 32'd64, 1'b0, 16'd4);

    // Sync on the would-be last sample wins: no dump there
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(32'h0101_0101, 1'b1, (i == 3));
      @(negedge clk);
      seen |= sum_valid;
    end
    check("sync_last_nodump", seen, 1'b0);
    expect_dump("sync_last", 32'd16, 1'b0, 16'd5);

    // Back-to-back windows: 16 then 64
    for (int i = 0; i < 8; i++) begin
      send((i < 4) ? 32'h0101_0101 : 32'h0202_0202, 1'b1, 1'b0);
      @(negedge clk);
      check("b2b_valid", sum_valid, (i == 6));
      if (i == 6) begin
        check("b2b_first_sum", sum_sq, 32'd16);
        check("b2b_first_cnt", dump_count, 16'd6);
      end
    end
    expect_dump("b2b_second", 32'd64, 1'b0, 16'd7);

    // Wide instance: saturation on first term is sticky through zeros
    send_w({4{16'h8000}}, 1'b1);
    repeat (3) send_w(64'd0, 1'b1);
    expect_dump_w("wsat_sticky", 32'hFFFF_FFFF, 1'b1, 16'd1);
    repeat (4) send_w(64'd0, 1'b1);
    expect_dump_w("wzero", 32'd0, 1'b0, 16'd2);
    repeat (3) send_w(64'd0, 1'b1);
    send_w({4{16'h8000}}, 1'b1);
    expect_dump_w("wsat_last", 32'hFFFF_FFFF, 1'b1, 16'd3);

    // Reset while a dump is in flight
    repeat (4) send(32'h0101_0101, 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_sum", sum_sq, 32'd0);
    check("midrst_cnt", dump_count, 16'd0);
    check("midrst_wcnt", w_dump_count, 16'd0);
    check("midrst_wsat", w_sum_sat, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      send(32'd0, 1'b0, 1'b0);
      @(negedge clk);
      seen |= sum_valid;
    end
    check("midrst_novalid", seen, 1'b0);
    check("midrst_sum_after", sum_sq, 32'd0);
    repeat (4) send(32'h0101_0101, 1'b1, 1'b0);
    expect_dump("post_rst", 32'd16, 1'b0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
